ifetch: RTL and testbench
=========================

// Module: ifetch
// PURPOSE
//  Instruction fetch unit: consumer side of pc. Reads pc.addr_out, issues one read at a
//  time to instruction memory (req/gnt, then rvalid), buffers returned words with their
//  addresses in a small FIFO for decode, and drives pc.en so the PC advances only per
//  accepted request. Sits between pc, imem and decode; flush aligns with pc.jmp.
// PARAMETERS
//  ADDR_WIDTH  32  address width (= PC_ADDR_WIDTH)
//  DATA_WIDTH  32  instruction word width
//  BUF_DEPTH   2   output FIFO entries (power of 2, >=2)
// PORTS
//  clk         in   1           clock, rising edge
//  reset       in   1           asynchronous, active-high reset
//  pc_addr     in   ADDR_WIDTH  current PC (pc.addr_out)
//  pc_en       out  1           advance PC (to pc.en)
//  flush       in   1           jump taken this cycle (same cycle as pc.jmp)
//  mem_req     out  1           read request to imem
//  mem_addr    out  ADDR_WIDTH  request address
//  mem_gnt     in   1           imem accepts request this cycle
//  mem_rvalid  in   1           read data valid
//  mem_rdata   in   DATA_WIDTH  read data
//  inst_valid  out  1           FIFO head valid
//  inst        out  DATA_WIDTH  FIFO head instruction
//  inst_addr   out  ADDR_WIDTH  FIFO head address
//  inst_ready  in   1           decode pops head when inst_valid & inst_ready
// BEHAVIOUR
//  - Reset (async): state IDLE, FIFO empty, all outputs 0; effect immediate, not clocked.
//  - FSM states IDLE, REQ, WAIT, DROP; at most one read outstanding.
//  - IDLE: mem_req=0. -> REQ when count<BUF_DEPTH (post-pop count) or flush.
//  - REQ: mem_req=1, mem_addr=pc_addr (combinational; stable because pc_en=0 until gnt).
//    On mem_gnt: latch req_addr=pc_addr, pc_en=1 for that cycle, -> WAIT.
//    No gnt: stay REQ, pc_en=0.
//  - WAIT: on mem_rvalid push {req_addr, mem_rdata}; -> REQ if count_next<BUF_DEPTH
//    else IDLE. No rvalid: stay.
//  - DROP: stale response pending; on mem_rvalid discard data, -> REQ. mem_req=0.
//  - pc_en = (state==REQ) & mem_gnt & ~flush. Never asserted in any other state.
//  - Flush (wins over everything except reset): FIFO cleared at next edge;
//    WAIT -> DROP (or -> REQ if mem_rvalid same cycle: data discarded, not pushed);
//    REQ with gnt same cycle -> DROP (request was for old path); REQ without gnt,
//    IDLE -> REQ; DROP stays DROP unless rvalid -> REQ.
//  - FIFO: inst_valid = count!=0; inst/inst_addr = head, registered storage. Push and
//    pop same cycle: count unchanged. Pointers wrap mod BUF_DEPTH. Flush + pop same
//    cycle: flush wins, inst_valid=0 next cycle.
//  - Pushes occur only with space guaranteed (issue gated on count<BUF_DEPTH).
//  - mem_rvalid in IDLE/REQ is ignored. rvalid never precedes gnt by protocol.
//  - Peak throughput: one instruction per 2 cycles (REQ, WAIT) with 1-cycle imem.
//  - Order preserved: inst_addr sequence equals granted mem_addr sequence minus drops.
// TESTING
//  1 gnt=1, rvalid 1 cycle after gnt, rdata=addr+0x1000, inst_ready=1 -> inst_addr
//    0,1,2,3 with inst 0x1000..0x1003; pc_en one pulse per grant; pc_addr=4 after 4.
//  2 inst_ready=0 from start -> 2 entries buffered (addr 0,1), then mem_req=0, pc_en=0,
//    pc holds 2; set inst_ready=1 -> pops 0,1, next fetch mem_addr=2.
//  3 mem_gnt low 3 cycles in REQ -> mem_req=1, mem_addr constant, pc_en=0 all 3 cycles,
//    pc_addr unchanged; gnt high -> single pc_en pulse.
//  4 flush (pc jmp to 0x33) while read of addr 5 in WAIT -> rdata for 5 discarded in
//    DROP, FIFO empty, next inst_addr=0x33.
//  5 flush in same cycle as gnt for addr 7 -> pc_en=0, state DROP, addr 7 never
//    delivered; next inst_addr=jump target.
//  6 reset asserted mid-WAIT -> outputs 0 within same cycle (before edge); stale
//    rvalid after release ignored; first fetch mem_addr=0, inst_addr=0.

Source files
------------

// File: rtl/ifetch.sv
// ifetch: instruction fetch unit, single outstanding imem read feeding a small decode FIFO
// Ports:
//   clk, reset                  clock (rising edge), asynchronous active-high reset
//   pc_addr / pc_en / flush     current PC in, PC advance out, jump-taken in
//   mem_req / mem_addr          read request and address to imem
//   mem_gnt / mem_rvalid / mem_rdata  imem accept, response valid, response data
//   inst_valid / inst / inst_addr / inst_ready  FIFO head towards decode
module ifetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc_addr,
  output logic                  pc_en,
  input  logic                  flush,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_addr,
  input  logic                  inst_ready
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;
  state_t state, state_next;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_pop, count_next;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] data_mem [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem [BUF_DEPTH];
  logic pop, push;
  always_comb begin
    pop        = inst_valid & inst_ready;
    push       = (state == WAIT) & mem_rvalid & ~flush;
    count_pop  = count - CW'(pop);
    count_next = count_pop + CW'(push);
    state_next = state;
    // flush steers every state towards the new path; a response already
    // granted for the old path must be swallowed in DROP
    case (state)
      IDLE:    state_next = (flush | (count_pop < CW'(BUF_DEPTH))) ? REQ : IDLE;
      REQ:     state_next = mem_gnt ? (flush ? DROP : WAIT) : REQ;
      WAIT:    state_next = mem_rvalid ? ((flush | (count_next < CW'(BUF_DEPTH))) ? REQ : IDLE)
                                       : (flush ? DROP : WAIT);
      default: state_next = mem_rvalid ? REQ : DROP;
    endcase
  end
  assign mem_req    = state == REQ;
  assign mem_addr   = mem_req ? pc_addr : '0;
  assign pc_en      = mem_req & mem_gnt & ~flush;
  assign inst_valid = count != '0;
  assign inst       = inst_valid ? data_mem[rd_ptr] : '0;
  assign inst_addr  = inst_valid ? addr_mem[rd_ptr] : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      req_addr <= '0;
    end else begin
      state <= state_next;
      if (mem_req & mem_gnt) req_addr <= pc_addr;
      if (flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        count <= count_next;
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= mem_rdata;
      addr_mem[wr_ptr] <= req_addr;
    end
  end
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed bench for ifetch with a PC model and a variable-latency imem model
module tb_ifetch;
  logic clk, reset, flush, inst_ready, gnt_en;
  logic pc_en, mem_req, mem_gnt, mem_rvalid, inst_valid;
  logic [31:0] pc, target, mem_addr, mem_rdata, inst, inst_addr, paddr;
  int lat, pcnt, checks, errors, pen_cnt, pen_base, q_base;
  bit pend;
  logic [31:0] got_addr[$], got_data[$];
  ifetch dut (
    .clk(clk), .reset(reset), .pc_addr(pc), .pc_en(pc_en), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .inst_valid(inst_valid), .inst(inst), .inst_addr(inst_addr),
    .inst_ready(inst_ready)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk or posedge reset)
    if (reset) pc <= 0;
    else if (flush) pc <= target;
    else if (pc_en) pc <= pc + 1;
  assign mem_gnt    = gnt_en & mem_req;
  assign mem_rvalid = pend && pcnt == 0;
  assign mem_rdata  = paddr + 32'h1000;
  always @(posedge clk) begin
    if (pend) begin
      if (pcnt == 0) pend <= 0;
      else pcnt <= pcnt - 1;
    end
    if (mem_req && mem_gnt) begin
      pend  <= 1;
      pcnt  <= lat;
      paddr <= mem_addr;
    end
  end
  always @(negedge clk)
    if (!reset) begin
      if (inst_valid && inst_ready && !flush) begin
        got_addr.push_back(inst_addr);
        got_data.push_back(inst);
      end
      if (pc_en) pen_cnt <= pen_cnt + 1;
    end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  function automatic int npen();
    return pen_cnt - pen_base;
  endfunction
  function automatic int ndlv();
    return got_addr.size() - q_base;
  endfunction
  function automatic logic [31:0] dlv_addr(input int i);
    return (q_base + i < got_addr.size()) ? got_addr[q_base + i] : 32'hdead_beef;
  endfunction
  function automatic logic [31:0] dlv_data(input int i);
    return (q_base + i < got_data.size()) ? got_data[q_base + i] : 32'hdead_beef;
  endfunction
  task automatic mark();
    pen_base = pen_cnt;
    q_base   = got_addr.size();
  endtask
  task automatic wait_dlv(input string tag, input int n, input int bound);
    for (int i = 0; i < bound && ndlv() < n; i++) tick(1);
    check(tag, ndlv() >= n, 1);
  endtask
  task automatic do_reset();
    gnt_en = 0;
    for (int i = 0; i < 20 && pend; i++) tick(1);
    reset = 1;
    tick(2);
    reset = 0;
    mark();
  endtask
  initial begin
    reset = 1; flush = 0; target = 0; gnt_en = 1; lat = 0; inst_ready = 1;
    checks = 0; errors = 0; pen_base = 0; q_base = 0;
    #1;
    check("rst_req", mem_req, 0);
    check("rst_pc_en", pc_en, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_inst", inst, 0);
    tick(2);
    reset = 0;
    mark();
    for (int i = 0; i < 40 && npen() < 4; i++) tick(1);
    gnt_en = 0;
    check("t1_pulses", npen(), 4);
    wait_dlv("t1_deliver", 4, 20);
    for (int i = 0; i < 4; i++) begin
      check("t1_addr", dlv_addr(i), i);
      check("t1_data", dlv_data(i), 32'h1000 + i);
    end
    check("t1_pc", pc, 4);
    check("t1_pulses_end", npen(), 4);
    do_reset();
    inst_ready = 0; gnt_en = 1;
    tick(10);
    check("t2_valid", inst_valid, 1);
    check("t2_head_addr", inst_addr, 0);
    check("t2_head_data", inst, 32'h1000);
    check("t2_req", mem_req, 0);
    check("t2_pc_en", pc_en, 0);
    check("t2_pc", pc, 2);
    check("t2_pulses", npen(), 2);
    inst_ready = 1; gnt_en = 0;
    tick(3);
    check("t2_ndlv", ndlv(), 2);
    check("t2_pop0", dlv_addr(0), 0);
    check("t2_pop1", dlv_addr(1), 1);
    check("t2_pop1_data", dlv_data(1), 32'h1001);
    check("t2_empty", inst_valid, 0);
    check("t2_req_again", mem_req, 1);
    check("t2_next_addr", mem_addr, 2);
    do_reset();
    for (int i = 0; i < 10 && !mem_req; i++) tick(1);
    for (int i = 0; i < 3; i++) begin
      check("t3_req", mem_req, 1);
      check("t3_addr", mem_addr, 0);
      check("t3_pc_en", pc_en, 0);
      check("t3_pc", pc, 0);
      tick(1);
    end
    gnt_en = 1;
    #1;
    check("t3_pulse", pc_en, 1);
    tick(1);
    check("t3_pulse_end", pc_en, 0);
    check("t3_pc_after", pc, 1);
    check("t3_pulses", npen(), 1);
    do_reset();
    lat = 2; gnt_en = 1;
    for (int i = 0; i < 60 && npen() < 6; i++) tick(1);
    check("t4_at5", pc, 6);
    flush = 1; target = 32'h33;
    #1;
    check("t4_pc_en", pc_en, 0);
    tick(1);
    flush = 0;
    mark();
    check("t4_valid", inst_valid, 0);
    check("t4_pc", pc, 32'h33);
    check("t4_drop_req", mem_req, 0);
    wait_dlv("t4_deliver", 1, 30);
    check("t4_addr", dlv_addr(0), 32'h33);
    check("t4_data", dlv_data(0), 32'h1033);
    do_reset();
    lat = 0; gnt_en = 1;
    for (int i = 0; i < 40 && !(pc == 7 && mem_req); i++) tick(1);
    check("t5_at7", mem_addr, 7);
    flush = 1; target = 32'h40;
    #1;
    check("t5_pc_en", pc_en, 0);
    tick(1);
    flush = 0;
    mark();
    check("t5_pc", pc, 32'h40);
    check("t5_drop_req", mem_req, 0);
    check("t5_valid", inst_valid, 0);
    wait_dlv("t5_deliver", 1, 20);
    check("t5_addr", dlv_addr(0), 32'h40);
    check("t5_data", dlv_data(0), 32'h1040);
    do_reset();
    lat = 3; gnt_en = 1;
    for (int i = 0; i < 10 && npen() < 1; i++) tick(1);
    gnt_en = 0;
    tick(1);
    #2;
    reset = 1;
    #1;
    check("t6_req", mem_req, 0);
    check("t6_pc_en", pc_en, 0);
    check("t6_valid", inst_valid, 0);
    check("t6_mem_addr", mem_addr, 0);
    tick(1);
    reset = 0;
    mark();
    tick(3);
    check("t6_stale_valid", inst_valid, 0);
    check("t6_stale_ndlv", ndlv(), 0);
    lat = 0; gnt_en = 1;
    #1;
    check("t6_first_req", mem_req, 1);
    check("t6_first_addr", mem_addr, 0);
    wait_dlv("t6_deliver", 1, 10);
    check("t6_addr", dlv_addr(0), 0);
    check("t6_data", dlv_data(0), 32'h1000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
